// File: rtl/pipelined_csel_adder_pkg.sv
// Shared definitions for the pipelined carry-select adder: default geometry
// and helpers that derive the stage count and validate the segmentation.
package csel_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_BLOCK = 8;

  // Number of pipeline stages: one per BLOCK-bit segment.
  function automatic int nblk(input int width, input int block);
    return width / block;
  endfunction

  // The operand must split into a whole, non-zero number of segments.
  function automatic bit geom_ok(input int width, input int block);
    return (block > 0) && (width >= block) && ((width % block) == 0);
  endfunction

endpackage

// File: rtl/pipelined_csel_adder_if.sv
// Operand/result stream for the pipelined carry-select adder. The master
// offers operands and consumes results; the slave is the adder itself.
interface pipelined_csel_adder_if
  import csel_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/pipelined_csel_adder_block.sv
// One carry-select segment: both candidate sums are formed in parallel and
// the incoming carry only drives the final select mux.
module csel_block
  import csel_pkg::*;
#(
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin_sel,
  output logic [BLOCK-1:0] sel_sum,
  output logic             sel_cout,
  output logic             msb_cin
);

  logic [BLOCK:0] s0;
  logic [BLOCK:0] s1;

  assign s0 = {1'b0, a} + {1'b0, b};
  assign s1 = {1'b0, a} + {1'b0, b} + {{BLOCK{1'b0}}, 1'b1};

  assign {sel_cout, sel_sum} = cin_sel ? s1 : s0;

  // Carry into the segment MSB falls out of the MSB sum bit and its operands.
  assign msb_cin = a[BLOCK-1] ^ b[BLOCK-1] ^ sel_sum[BLOCK-1];

endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor. Segment k resolves in stage k;
// upper operand segments ride along (skew) and finished lower sum segments
// ride forward (de-skew) so the full result aligns in the last stage.
module pipelined_csel_adder
  import csel_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLOCK = DEF_BLOCK
) (
  input logic                  clk,
  input logic                  rst,
  pipelined_csel_adder_if.slave bus
);

  localparam int NBLK = nblk(WIDTH, BLOCK);

  if (!geom_ok(WIDTH, BLOCK)) begin : g_geom_check
    $error("pipelined_csel_adder: WIDTH must be a positive multiple of BLOCK");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  logic             vld_p   [NBLK];
  logic             carry_p [NBLK];
  logic [WIDTH-1:0] res_p   [NBLK];
  logic [WIDTH-1:0] opa_p   [NBLK];
  logic [WIDTH-1:0] opb_p   [NBLK];
  logic             ovf_p;

  logic [BLOCK-1:0] seg_a    [NBLK];
  logic [BLOCK-1:0] seg_b    [NBLK];
  logic             seg_cin  [NBLK];
  logic [BLOCK-1:0] sel_sum  [NBLK];
  logic             sel_cout [NBLK];
  logic             msb_cin  [NBLK];

  // The whole pipeline moves as one unit; it only stops for a held result.
  assign advance      = ~bus.out_valid | bus.out_ready;
  assign bus.in_ready = advance;

  // Subtraction folds into addition of the inverted operand plus one.
  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign c0    = bus.sub | bus.cin;

  for (genvar k = 0; k < NBLK; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign seg_a[k]   = bus.a[BLOCK-1:0];
      assign seg_b[k]   = b_eff[BLOCK-1:0];
      assign seg_cin[k] = c0;
    end else begin : g_next
      assign seg_a[k]   = opa_p[k-1][k*BLOCK +: BLOCK];
      assign seg_b[k]   = opb_p[k-1][k*BLOCK +: BLOCK];
      assign seg_cin[k] = carry_p[k-1];
    end

    csel_block #(
      .BLOCK (BLOCK)
    ) u_blk (
      .a        (seg_a[k]),
      .b        (seg_b[k]),
      .cin_sel  (seg_cin[k]),
      .sel_sum  (sel_sum[k]),
      .sel_cout (sel_cout[k]),
      .msb_cin  (msb_cin[k])
    );
  end

  // Stage registers: valid, segment carry, partial result and skewed operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_p <= 1'b0;
      for (int k = 0; k < NBLK; k++) begin
        vld_p[k]   <= 1'b0;
        carry_p[k] <= 1'b0;
        res_p[k]   <= '0;
        opa_p[k]   <= '0;
        opb_p[k]   <= '0;
      end
    end else if (advance) begin
      vld_p[0]              <= bus.in_valid;
      carry_p[0]            <= sel_cout[0];
      res_p[0]              <= '0;
      res_p[0][BLOCK-1:0]   <= sel_sum[0];
      opa_p[0]              <= bus.a;
      opb_p[0]              <= b_eff;
      for (int k = 1; k < NBLK; k++) begin
        vld_p[k]                   <= vld_p[k-1];
        carry_p[k]                 <= sel_cout[k];
        res_p[k]                   <= res_p[k-1];
        res_p[k][k*BLOCK +: BLOCK] <= sel_sum[k];
        opa_p[k]                   <= opa_p[k-1];
        opb_p[k]                   <= opb_p[k-1];
      end
      ovf_p <= sel_cout[NBLK-1] ^ msb_cin[NBLK-1];
    end
  end

  assign bus.out_valid = vld_p[NBLK-1];
  assign bus.sum       = res_p[NBLK-1];
  assign bus.cout      = carry_p[NBLK-1];
  assign bus.ovf       = ovf_p;

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Directed and random checks of the pipelined carry-select adder in an
// 8-bit/4-bit-segment build and a 32-bit/8-bit-segment build.
module tb_pipelined_csel_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t q8[$];
  exp_t q32[$];
  exp_t m8;
  exp_t m32;

  pipelined_csel_adder_if #(.WIDTH(8))  i8 ();
  pipelined_csel_adder_if #(.WIDTH(32)) i32 ();

  pipelined_csel_adder #(.WIDTH(8), .BLOCK(4)) d8 (
    .clk (clk),
    .rst (rst),
    .bus (i8)
  );

  pipelined_csel_adder #(.WIDTH(32), .BLOCK(8)) d32 (
    .clk (clk),
    .rst (rst),
    .bus (i32)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model32(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
    exp_t        e;
    logic [31:0] be;
    logic [32:0] t;
    be     = sub ? ~b : b;
    t      = {1'b0, a} + {1'b0, be} + {32'd0, (sub ? 1'b1 : cin)};
    e.sum  = t[31:0];
    e.cout = t[32];
    e.ovf  = (a[31] == be[31]) && (t[31] != a[31]);
    e.acc  = 0;
    e.lat  = 1'b0;
    return e;
  endfunction

  task automatic accept8(input exp_t e);
    bit ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (i8.in_ready) ok = 1'b1;
      else begin
        @(posedge clk); #1;
        i8.out_ready = 1'b1;
      end
    end
    chk("d8_accept", {31'd0, ok}, 32'd1);
    if (ok) begin
      e.acc = cyc + 1;
      q8.push_back(e);
    end
    @(posedge clk); #1;
    i8.in_valid = 1'b0;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic su);
    i8.a = a; i8.b = b; i8.cin = ci; i8.sub = su;
    i8.in_valid = 1'b1;
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic su,
                       input logic [7:0] es, input logic ec, input logic eo, input bit lat);
    exp_t e;
    e.sum = {24'd0, es}; e.cout = ec; e.ovf = eo; e.acc = 0; e.lat = lat;
    drive8(a, b, ci, su);
    accept8(e);
  endtask

  task automatic drain8();
    int n = 0;
    while ((q8.size() != 0 || i8.out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("d8_drain_left", q8.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic accept32(input exp_t e);
    bit ok = 1'b0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      if (i32.in_ready) ok = 1'b1;
      else begin
        @(posedge clk); #1;
        i32.out_ready = 1'b1;
      end
    end
    chk("d32_accept", {31'd0, ok}, 32'd1);
    if (ok) begin
      e.acc = cyc + 1;
      q32.push_back(e);
    end
    @(posedge clk); #1;
    i32.in_valid = 1'b0;
  endtask

  task automatic drive32(input logic [31:0] a, input logic [31:0] b, input logic ci, input logic su);
    i32.a = a; i32.b = b; i32.cin = ci; i32.sub = su;
    i32.in_valid = 1'b1;
  endtask

  task automatic drain32();
    int n = 0;
    while ((q32.size() != 0 || i32.out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("d32_drain_left", q32.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  // Scoreboard for the 8-bit build: compare every result as it is accepted.
  always @(negedge clk) begin
    if (!rst && i8.out_valid && i8.out_ready) begin
      chk("d8_result_expected", {31'd0, (q8.size() != 0)}, 32'd1);
      if (q8.size() != 0) begin
        m8 = q8.pop_front();
        chk("d8_sum", {24'd0, i8.sum}, m8.sum);
        chk("d8_cout", {31'd0, i8.cout}, {31'd0, m8.cout});
        chk("d8_ovf", {31'd0, i8.ovf}, {31'd0, m8.ovf});
        if (m8.lat) chk("d8_latency", cyc - m8.acc, 32'd1);
      end
    end
  end

  // Scoreboard for the 32-bit build.
  always @(negedge clk) begin
    if (!rst && i32.out_valid && i32.out_ready) begin
      chk("d32_result_expected", {31'd0, (q32.size() != 0)}, 32'd1);
      if (q32.size() != 0) begin
        m32 = q32.pop_front();
        chk("d32_sum", i32.sum, m32.sum);
        chk("d32_cout", {31'd0, i32.cout}, {31'd0, m32.cout});
        chk("d32_ovf", {31'd0, i32.ovf}, {31'd0, m32.ovf});
        if (m32.lat) chk("d32_latency", cyc - m32.acc, 32'd3);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    i8.in_valid = 1'b0;  i8.a = '0;  i8.b = '0;  i8.cin = 1'b0;  i8.sub = 1'b0;  i8.out_ready = 1'b0;
    i32.in_valid = 1'b0; i32.a = '0; i32.b = '0; i32.cin = 1'b0; i32.sub = 1'b0; i32.out_ready = 1'b0;

    // Reset state, with out_ready low so in_ready must come from out_valid=0.
    @(posedge clk); #1;
    chk("rst_out_valid8", {31'd0, i8.out_valid}, 32'd0);
    chk("rst_in_ready8", {31'd0, i8.in_ready}, 32'd1);
    chk("rst_sum8", {24'd0, i8.sum}, 32'd0);
    chk("rst_out_valid32", {31'd0, i32.out_valid}, 32'd0);
    chk("rst_in_ready32", {31'd0, i32.in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    i8.out_ready = 1'b1;
    i32.out_ready = 1'b1;

    // Back-to-back adds, results one per cycle two cycles after input.
    send8(8'd15,  8'd10,  1'b0, 1'b0, 8'd25,  1'b0, 1'b0, 1'b1);
    send8(8'd25,  8'd50,  1'b1, 1'b0, 8'd76,  1'b0, 1'b0, 1'b1);
    send8(8'd100, 8'd155, 1'b0, 1'b0, 8'd255, 1'b0, 1'b0, 1'b1);
    send8(8'd200, 8'd55,  1'b1, 1'b0, 8'd0,   1'b1, 1'b0, 1'b1);
    drain8();

    // Subtraction, borrow and signed overflow; cin=1 must be ignored on sub.
    send8(8'd10,  8'd15,  1'b0, 1'b1, 8'd251, 1'b0, 1'b0, 1'b1);
    send8(8'd128, 8'd1,   1'b1, 1'b1, 8'd127, 1'b1, 1'b1, 1'b1);
    send8(8'd100, 8'd100, 1'b0, 1'b0, 8'd200, 1'b0, 1'b1, 1'b1);
    drain8();

    // Backpressure: two inputs fill the pipe, a third waits during the stall.
    i8.out_ready = 1'b0;
    send8(8'd1, 8'd2, 1'b0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0);
    send8(8'd3, 8'd4, 1'b0, 1'b0, 8'd7, 1'b0, 1'b0, 1'b0);
    drive8(8'd5, 8'd6, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, i8.in_ready}, 32'd0);
      chk("stall_out_valid", {31'd0, i8.out_valid}, 32'd1);
      chk("stall_sum_hold", {24'd0, i8.sum}, 32'd3);
    end
    @(posedge clk); #1;
    i8.out_ready = 1'b1;
    e.sum = 32'd11; e.cout = 1'b0; e.ovf = 1'b0; e.acc = 0; e.lat = 1'b0;
    accept8(e);
    drain8();

    // Carries crossing the segment boundary.
    send8(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1);
    send8(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    drain8();

    // Asynchronous reset with two valid stages in flight.
    send8(8'h11, 8'h22, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0);
    send8(8'h44, 8'h55, 1'b0, 1'b0, 8'h99, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, i8.out_valid}, 32'd0);
    chk("midrst_sum", {24'd0, i8.sum}, 32'd0);
    chk("midrst_cout", {31'd0, i8.cout}, 32'd0);
    i8.out_ready = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, i8.in_ready}, 32'd1);
    q8.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    i8.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("postrst_no_stale", {31'd0, i8.out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    send8(8'h21, 8'h12, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1);
    drain8();

    // Wide build: full-width carry ripple through all four stages.
    e.sum = 32'd0; e.cout = 1'b1; e.ovf = 1'b0; e.acc = 0; e.lat = 1'b1;
    drive32(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
    accept32(e);
    e.sum = 32'h8000_0000; e.cout = 1'b0; e.ovf = 1'b1; e.acc = 0; e.lat = 1'b1;
    drive32(32'h7FFF_FFFF, 32'd0, 1'b1, 1'b0);
    accept32(e);
    drain32();

    // Random operands with intermittent backpressure.
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rc;
      logic        rs;
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      i32.out_ready = ($urandom_range(0, 3) != 0);
      e = model32(ra, rb, rc, rs);
      drive32(ra, rb, rc, rs);
      accept32(e);
    end
    i32.out_ready = 1'b1;
    drain32();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipelined_csel_adder.md
# pipelined_csel_adder

Parametrised, pipelined carry-select adder/subtractor. It is the successor to the fixed 8-bit combinational carry-select adder. Operands are split into BLOCK-bit segments, and each segment resolves in its own pipeline stage using precomputed carry-0/carry-1 sums. Results stream out at one per clock behind a valid/ready handshake with full backpressure. It serves as the wide-add datapath primitive for the arithmetic blocks that follow.

## Interface
Parameters:
- WIDTH, 32, operand/sum width; must be a multiple of BLOCK.
- BLOCK, 8, segment width; NBLK = WIDTH/BLOCK pipeline stages, NBLK ≥ 1.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands this cycle.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  1: compute a − b (a + ~b + 1); 0: a + b + cin.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result modulo 2^WIDTH.
- cout  out  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Clock and reset: one clock, clk; reset is asynchronous and active-high, rst.
- Effective operands: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
- Stage k (0..NBLK−1) handles segment k:
  - computes s0 = a_k + b_k + 0 and s1 = a_k + b_k + 1, each with carry-out;
  - selects one using the carry registered from stage k−1 (stage 0 uses c0);
  - registers the selected segment sum and carry.
- Skew registers: operand segments k+1..NBLK−1 travel alongside stage k.
- De-skew registers: completed low segments travel forward so the full sum aligns at the last stage.
- Last stage: also registers carry-into-MSB to form ovf.
- Each stage carries a valid bit. Global advance = ~out_valid | out_ready. All stage registers load only when advance=1.
- in_ready = advance (combinational from out_valid/out_ready). An input is accepted when in_valid & in_ready.
- A bubble (in_valid=0 while advancing) inserts valid=0 into stage 0.
- Arithmetic is exact modulo 2^WIDTH. cout and ovf are defined for every result, signed or unsigned.

## Timing
- Latency: a transfer accepted at edge e appears on sum/cout/ovf with out_valid=1 after edge e+NBLK−1, i.e. NBLK cycles. NBLK=1 degenerates to a single registered adder.
- Throughput: one result per clock while out_ready=1; no bubbles between back-to-back inputs.
- Stall: out_valid=1 & out_ready=0 freezes every stage.
  - sum/cout/ovf hold stable until the output is accepted.
  - in_ready=0 during the stall.
  - No data is lost or duplicated.
- Pipeline drains with in_valid=0: results exit in order; out_valid falls once the last valid stage empties.
- Simultaneous output accept and input accept in one cycle is legal and required.
- Reset: rst=1 clears all valid bits, sum, cout, ovf and all skew/de-skew registers to 0, immediately and independent of clk.
  - out_valid=0 during reset; in_ready=1 during reset.
  - Reset mid-operation discards all in-flight operations; first output after release comes only from post-reset inputs.
- No combinational path from a/b/cin/sub to any output. The only combinational input-to-output path is out_ready → in_ready.

## Structure
- Shared package csel_pkg:
  - function nblk(WIDTH, BLOCK);
  - elaboration check that WIDTH % BLOCK == 0;
  - localparam defaults.
- Sub-module csel_block (combinational, BLOCK-bit):
  - inputs a, b, cin_sel;
  - outputs sel_sum, sel_cout, msb_cin;
  - contains the two ripple sums and the select mux.
- Top instantiates NBLK csel_block under a generate loop, with per-stage valid/data registers.

## Test plan
Use WIDTH=8, BLOCK=4 (latency 2) for scenarios 1–5.
1. Adds, out_ready=1, back-to-back:
   - 15+10 c0 → 25, cout 0;
   - 25+50 c1 → 76;
   - 100+155 c0 → 255, cout 0;
   - 200+55 c1 → 0, cout 1.
   - Results on consecutive cycles, each 2 cycles after its input.
2. Subtract and overflow:
   - sub: 10−15 → 251, cout 0, ovf 0;
   - sub: 128−1 → 127, cout 1, ovf 1;
   - add: 100+100 → 200, ovf 1.
3. Backpressure:
   - hold out_ready=0 for 5 cycles with three inputs offered;
   - sum stays stable, in_ready=0 while out_valid=1;
   - release → all three results in order, none dropped or duplicated.
4. Carry crossing a segment: 0x0F+0x01 → 0x10; 0xFF+0x00 with cin=1 → 0x00, cout 1.
5. Reset mid-flight: assert rst asynchronously with 2 valid stages → out_valid=0 immediately; no stale output after release.
6. WIDTH=32, BLOCK=8: 0xFFFFFFFF+1 → 0, cout 1, appears 4 cycles after accept; 1000 random pairs checked against a reference model.
